// File: rtl/bus_mem_responder.sv
// Single-port 64-bit word memory answering the core's fetch and data buses.
// Fixed response latency, one transaction in flight, dbus wins arbitration.
module bus_mem_responder #(
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          DEPTH   = 65536,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid_i,
    input  logic [63:0] ireq_addr_i,
    output logic        iresp_data_ok_o,
    output logic [31:0] iresp_data_o,
    input  logic        dreq_valid_i,
    input  logic [63:0] dreq_addr_i,
    input  logic [2:0]  dreq_size_i,
    input  logic [7:0]  dreq_strobe_i,
    input  logic [63:0] dreq_data_i,
    output logic        dresp_data_ok_o,
    output logic [63:0] dresp_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt_d_q, gnt_d_d;
    logic [31:0]   idata_q, idata_d;
    logic [63:0]   ddata_q, ddata_d;
    logic [63:0]   mem_q [DEPTH];

    logic [63:0]   addr, off, rd_word, wr_word;
    logic [AW-1:0] idx;
    logic          in_range, gnt_valid, resp_i, resp_d, wr_en;
    logic          unused_w;

    // The granted request's fields drive the single memory port.
    assign addr      = gnt_d_q ? dreq_addr_i : ireq_addr_i;
    assign off       = addr - BASE;
    assign in_range  = (addr >= BASE) && (off < SPAN);
    assign idx       = off[AW+2:3];
    assign rd_word   = in_range ? mem_q[idx] : '0;
    assign gnt_valid = gnt_d_q ? dreq_valid_i : ireq_valid_i;
    assign resp_d    = (state_q == RESP) && gnt_d_q;
    assign resp_i    = (state_q == RESP) && !gnt_d_q;
    assign wr_en     = resp_d && in_range && (dreq_strobe_i != 8'h00);
    assign unused_w  = ^{dreq_size_i, off[2:0]};

    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 8; b++) begin
            if (dreq_strobe_i[b]) begin
                wr_word[8*b +: 8] = dreq_data_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d_d = gnt_d_q;
        idata_d = idata_q;
        ddata_d = ddata_q;
        unique case (state_q)
            IDLE: begin
                if (dreq_valid_i || ireq_valid_i) begin
                    gnt_d_d = dreq_valid_i;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (!gnt_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (gnt_d_q) begin
                    ddata_d = rd_word;
                end else begin
                    idata_d = addr[2] ? rd_word[63:32] : rd_word[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_d_q <= 1'b0;
            idata_q <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_d_q <= gnt_d_d;
            idata_q <= idata_d;
            ddata_q <= ddata_d;
        end
    end

    // Read-before-write: the old word is returned in the same RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign iresp_data_ok_o = resp_i;
    assign dresp_data_ok_o = resp_d;
    assign iresp_data_o    = idata_d;
    assign dresp_data_o    = ddata_d;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench for bus_mem_responder: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the memory.
module tb_bus_mem_responder;
    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] TOP   = BASE + 64'(DEPTH) * 64'd8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iv, iok, dv, dok;
    logic [63:0] ia, da, dd, ddat;
    logic [31:0] idat;
    logic [2:0]  dsz;
    logic [7:0]  dst;
    logic iv1, iok1, dv1, dok1;
    logic [63:0] ia1, da1, dd1, ddat1;
    logic [31:0] idat1;
    logic [2:0]  dsz1;
    logic [7:0]  dst1;

    int cyc = 0;
    int nt = 0;
    int nf = 0;

    bus_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .ireq_valid_i(iv), .ireq_addr_i(ia),
        .iresp_data_ok_o(iok), .iresp_data_o(idat),
        .dreq_valid_i(dv), .dreq_addr_i(da), .dreq_size_i(dsz),
        .dreq_strobe_i(dst), .dreq_data_i(dd),
        .dresp_data_ok_o(dok), .dresp_data_o(ddat)
    );

    bus_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .ireq_valid_i(iv1), .ireq_addr_i(ia1),
        .iresp_data_ok_o(iok1), .iresp_data_o(idat1),
        .dreq_valid_i(dv1), .dreq_addr_i(da1), .dreq_size_i(dsz1),
        .dreq_strobe_i(dst1), .dreq_data_i(dd1),
        .dresp_data_ok_o(dok1), .dresp_data_o(ddat1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: one transaction at a time, response LAT cycles after acceptance.
    logic [63:0] mm [longint];
    int          free_at = 0;
    int          resp_at = 0;
    bit          pend = 0;
    bit          pgd = 0;
    logic [31:0] e_id = '0;
    logic [63:0] e_dd = '0;
    bit          k_i = 1;
    bit          k_d = 1;

    always @(negedge clk) begin
        logic [63:0] a, w;
        longint      idx;
        bit          inr, kw, e_iok, e_dok;
        e_iok = 0;
        e_dok = 0;
        if (reset) begin
            pend = 0;
            free_at = cyc + 1;
            e_id = '0;
            e_dd = '0;
            k_i = 1;
            k_d = 1;
        end else begin
            if (pend && cyc < resp_at && !(pgd ? dv : iv)) begin
                pend = 0;
                free_at = cyc + 1;
            end
            if (!pend && cyc >= free_at && (dv || iv)) begin
                pend = 1;
                pgd = dv;
                resp_at = cyc + LAT;
            end
            if (pend && cyc == resp_at) begin
                a = pgd ? da : ia;
                inr = (a >= BASE) && (a < TOP);
                idx = longint'((a - BASE) >> 3);
                kw = !inr || mm.exists(idx);
                w = (inr && kw) ? mm[idx] : 64'h0;
                if (pgd) begin
                    e_dok = 1;
                    e_dd = w;
                    k_d = kw;
                    if (inr && dst != 8'h00) begin
                        for (int b = 0; b < 8; b++)
                            if (dst[b]) w[8*b +: 8] = dd[8*b +: 8];
                        if (kw || dst == 8'hFF) mm[idx] = w;
                    end
                end else begin
                    e_iok = 1;
                    e_id = a[2] ? w[63:32] : w[31:0];
                    k_i = kw;
                end
                pend = 0;
                free_at = cyc + 1;
            end
            chk("iresp.data_ok", 64'(iok), 64'(e_iok));
            chk("dresp.data_ok", 64'(dok), 64'(e_dok));
            if (k_i) chk("iresp.data", 64'(idat), 64'(e_id));
            if (k_d) chk("dresp.data", ddat, e_dd);
        end
    end

    task automatic d_go(input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, output logic [63:0] r,
                        output int lat);
        @(posedge clk); #1;
        dv = 1'b1; da = a; dst = s; dd = d; dsz = 3'd3;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dok && lat < 50);
        if (!dok) chk("dbus timeout", 64'(dok), 64'd1);
        lat--;
        r = ddat;
    endtask

    task automatic i_go(input logic [63:0] a, output logic [31:0] r,
                        output int lat);
        @(posedge clk); #1;
        iv = 1'b1; ia = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!iok && lat < 50);
        if (!iok) chk("ibus timeout", 64'(iok), 64'd1);
        lat--;
        r = idat;
    endtask

    task automatic d_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            dv = 1'b0;
        end
    endtask

    task automatic i_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            iv = 1'b0;
        end
    endtask

    function automatic logic [63:0] raddr();
        logic [63:0] l;
        l = 64'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return 64'h1000 + l;
            1: return 64'h9000_0000 + l;
            2: return TOP + l;
            3: return TOP - 64'd8 + l;
            default: return BASE + 64'($urandom_range(0, 15)) * 64'd8 + l;
        endcase
    endfunction

    function automatic logic [63:0] iaddr();
        if ($urandom_range(0, 9) == 0) return TOP + 64'd4;
        return BASE + 64'($urandom_range(0, 31)) * 64'd4;
    endfunction

    task automatic d_rand(input int n);
        logic [63:0] r;
        int lat;
        for (int k = 0; k < n; k++) begin
            d_idle($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                dv = 1'b1; da = raddr(); dst = 8'hFF;
                dd = {$urandom, $urandom};
            end else begin
                d_go(raddr(), $urandom_range(0, 1) ? 8'h00 : 8'($urandom),
                     {$urandom, $urandom}, r, lat);
            end
        end
        d_idle(1);
    endtask

    task automatic i_rand(input int n);
        logic [31:0] r;
        int lat;
        for (int k = 0; k < n; k++) begin
            i_idle($urandom_range(0, 2));
            i_go(iaddr(), r, lat);
        end
        i_idle(1);
    endtask

    task automatic rst_rand(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(40, 80)) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        logic [31:0] ri;
        int lat, t0, dt, it;
        logic [31:0] e6 [4];
        iv = 0; ia = '0; dv = 0; da = '0; dd = '0; dsz = '0; dst = '0;
        iv1 = 0; ia1 = '0; dv1 = 0; da1 = '0; dd1 = '0; dsz1 = '0;
        dst1 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset dresp.data", ddat, 64'h0);
        chk("reset iresp.data", 64'(idat), 64'h0);
        chk("reset data_ok", 64'({iok, dok}), 64'h0);

        for (int k = 0; k < 16; k++) begin
            d_go(BASE + 64'(k) * 8, 8'hFF, {$urandom, $urandom}, r, lat);
            d_idle(1);
        end
        d_go(TOP - 8, 8'hFF, 64'h0BAD_F00D_1234_5678, r, lat);
        d_idle(1);

        d_go(BASE, 8'hFF, 64'h1122334455667788, r, lat);
        d_idle(1);
        chk("model word0", mm[0], 64'h1122334455667788);
        i_go(BASE + 4, ri, lat);
        chk("fetch hi latency", 64'(lat), 64'd2);
        chk("fetch hi data", 64'(ri), 64'h11223344);
        i_go(BASE, ri, lat);
        chk("fetch lo data", 64'(ri), 64'h55667788);
        i_idle(1);

        d_go(BASE + 16, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, r, lat);
        d_go(BASE + 16, 8'h0F, 64'hAAAABBBB_CCCCDDDD, r, lat);
        chk("strobe write old", r, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("write latency", 64'(lat), 64'd2);
        d_go(BASE + 16, 8'h00, 64'h0, r, lat);
        chk("strobe merge", r, 64'hFFFFFFFF_CCCCDDDD);
        chk("model word2", mm[2], 64'hFFFFFFFF_CCCCDDDD);
        d_idle(1);

        @(posedge clk); #1;
        t0 = cyc; dt = -1; it = -1;
        dv = 1; da = BASE + 16; dst = 8'h00; iv = 1; ia = BASE;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("exclusive data_ok", 64'(dok & iok), 64'd0);
            if (dok) dt = cyc;
            if (iok) it = cyc;
            @(posedge clk); #1;
            if (dt >= 0) dv = 0;
            if (it >= 0) iv = 0;
        end
        chk("simul dbus cycle", 64'(dt - t0), 64'd2);
        chk("simul ibus cycle", 64'(it - t0), 64'd5);

        d_go(64'h1000, 8'h00, 64'h0, r, lat);
        chk("below base data", r, 64'h0);
        chk("below base latency", 64'(lat), 64'd2);
        d_go(64'h9000_0000, 8'hFF, 64'h5555_5555_5555_5555, r, lat);
        d_go(BASE, 8'h00, 64'h0, r, lat);
        chk("oor write dropped", r, 64'h1122334455667788);
        d_go(TOP, 8'hFF, 64'h0, r, lat);
        d_go(TOP - 8, 8'h00, 64'h0, r, lat);
        chk("last word", r, 64'h0BAD_F00D_1234_5678);
        d_go(TOP, 8'h00, 64'h0, r, lat);
        chk("top read zero", r, 64'h0);
        d_idle(1);

        @(posedge clk); #1;
        dv = 1; da = BASE; dst = 8'hFF; dd = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; dv = 0;
        @(negedge clk);
        chk("post-reset dok", 64'(dok), 64'd0);
        chk("post-reset ddata", ddat, 64'h0);
        d_go(BASE, 8'h00, 64'h0, r, lat);
        chk("reset drops write", r, 64'h1122334455667788);
        chk("post-reset latency", 64'(lat), 64'd2);
        d_idle(1);

        @(posedge clk); #1;
        dv1 = 1; da1 = BASE; dst1 = 8'hFF; dd1 = 64'h0123456789ABCDEF;
        @(negedge clk);
        @(negedge clk);
        chk("l1 write0 ok", 64'(dok1), 64'd1);
        @(posedge clk); #1;
        da1 = BASE + 8; dd1 = 64'hFEDCBA98_76543210;
        @(negedge clk);
        @(negedge clk);
        chk("l1 write1 ok", 64'(dok1), 64'd1);
        @(posedge clk); #1;
        dv1 = 0;
        e6[0] = 32'h89ABCDEF; e6[1] = 32'h01234567;
        e6[2] = 32'h76543210; e6[3] = 32'hFEDCBA98;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            iv1 = 1; ia1 = BASE + 64'(k) * 4;
            @(negedge clk);
            chk("l1 fetch gap", 64'(iok1), 64'd0);
            @(negedge clk);
            chk("l1 fetch ok", 64'(iok1), 64'd1);
            chk("l1 fetch data", 64'(idat1), 64'(e6[k]));
            chk("l1 no dok", 64'(dok1), 64'd0);
        end
        @(posedge clk); #1;
        iv1 = 0;

        fork
            d_rand(150);
            i_rand(150);
            rst_rand(5);
        join
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule
